// File: rtl/fc_act_collector_pkg.sv
// Shared definitions for the fully-connected activation collector.
//   state_e  : collector FSM states (FILL gathers neurons, HOLD presents the vector)
//   acc_w()  : accumulator width for a given activation width and fan-in
//   sat_max(): largest non-negative value of a signed WIDTH-bit activation
package fc_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Dot product of IN products of two WIDTH-bit values grows by $clog2(IN) bits.
  function automatic int acc_w(input int width, input int fan_in);
    return width * 2 + $clog2(fan_in);
  endfunction

  localparam int ACC_W_DEF = acc_w(8, 128);

  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/fc_act_collector_if.sv
// Handshake bundle between the neuron units, the collector and the next layer.
//   in_valid/in_ready/in_data/in_last : one accumulator word per handshake
//   out_valid/out_ready/out_x         : complete requantized activation vector
//   seq_err                           : sticky in_last/count disagreement flag
// slave modport is the collector side, master is the producer/consumer side.
interface fc_act_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 23,
  parameter int OUT   = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [ACC_W-1:0] in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_x [0:OUT-1];
  logic                    seq_err;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_x, seq_err
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_x, seq_err
  );
endinterface

// File: rtl/fc_act_collector_requant_sat.sv
// Combinational requantizer: signed accumulator word -> non-negative WIDTH-bit
// activation. Negative inputs clamp to 0, positive inputs are rounded half-up
// after a right shift by SHIFT and saturated to the signed WIDTH-bit maximum.
//   a : signed accumulator input (ACC_W bits)
//   q : requantized activation (WIDTH bits, always <= 2^(WIDTH-1)-1)
module requant_sat
  import fc_pkg::*;
#(
  parameter int ACC_W = 23,
  parameter int WIDTH = 8,
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0] a,
  output logic [WIDTH-1:0]        q
);

  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SHIFT - 1);
  localparam logic [ACC_W:0] QMAX = (ACC_W + 1)'(sat_max(WIDTH));

  // One extra bit of headroom so the rounding add of the largest positive
  // accumulator value cannot wrap.
  function automatic logic [ACC_W:0] rnd_half_up(input logic signed [ACC_W-1:0] v);
    logic [ACC_W:0] s;
    s = {1'b0, v} + HALF;
    return s >> SHIFT;
  endfunction

  function automatic logic [WIDTH-1:0] sat_clip(input logic [ACC_W:0] t);
    if (t > QMAX) return QMAX[WIDTH-1:0];
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    q = '0;
    if (!a[ACC_W-1]) q = sat_clip(rnd_half_up(a));
  end

endmodule

// File: rtl/fc_act_collector.sv
// Output collector of a fully-connected layer. Accepts OUT accumulator words
// in neuron order, requantizes each into its slot of out_x, then holds the
// full vector with out_valid until the next layer takes it.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fc_act_if slave (input word handshake, output vector handshake,
//              sticky seq_err)
module fc_act_collector
  import fc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int ACC_W = acc_w(WIDTH, IN),
  parameter int OUT   = 10,
  parameter int SHIFT = 7
) (
  input  logic        clk,
  input  logic        rst,
  fc_act_if.slave     bus
);

  localparam int               CNT_W = $clog2(OUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(OUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seq_err_q, seq_err_d;
  logic [WIDTH-1:0] buf_q [0:OUT-1];
  logic [WIDTH-1:0] rq_val;
  logic             accept;
  logic             at_last;

  requant_sat #(
    .ACC_W (ACC_W),
    .WIDTH (WIDTH),
    .SHIFT (SHIFT)
  ) u_rq (
    .a (bus.in_data),
    .q (rq_val)
  );

  assign accept  = bus.in_valid && (state_q == FILL);
  assign at_last = (cnt_q == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seq_err_q <= seq_err_d;
    end
  end

  // Next-state logic; the vector closes on the count alone, in_last only
  // feeds the error flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seq_err_d = seq_err_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          seq_err_d = seq_err_q | (bus.in_last != at_last);
          if (at_last) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready  = (state_q == FILL);
    bus.out_valid = (state_q == HOLD);
    bus.seq_err   = seq_err_q;
  end

  // Vector storage: written only on accepted words, so slots not yet
  // overwritten keep the previous vector's values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUT; i++) buf_q[i] <= '0;
    end else if (accept) begin
      buf_q[cnt_q] <= rq_val;
    end
  end

  assign bus.out_x = buf_q;

endmodule
